// File: rtl/wb_uart_master.sv
// UART-driven Wishbone initiator: framed serial commands become single 32-bit
// bus cycles, with status and read data returned on the serial transmit line.
module wb_uart_master #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] STS_OK    = 8'h00;
    localparam logic [7:0] STS_ERR   = 8'hEE;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_sync, rx_prev;
    logic             rx_active, rx_valid, rx_ferr;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             tx_active;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_shift;
    logic [1:0]       byte_cnt;
    logic             is_write;
    logic [31:0]      addr, wdata, rdata;
    logic [7:0]       status;
    logic [TMO_W-1:0] timer;
    logic [2:0]       resp_idx, resp_total;
    logic             tx_done_c, tx_load_c, byte_in_c, bus_start_c, bus_end_c;
    logic [7:0]       tx_byte_c;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive sequencer: rx_bit 0 = start (checked at half bit), 1..8 data, 9 stop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_active) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                if (rx_prev && !rx_sync) rx_active <= 1'b1;
            end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    if (rx_sync) rx_active <= 1'b0;
                    else         rx_bit    <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_valid  <= rx_sync;
                    rx_ferr   <= !rx_sync;
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Transmit sequencer: a load on the final stop cycle chains bytes with no gap
    assign tx_done_c = tx_active && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            o_uart_tx <= 1'b1;
        end else if (tx_load_c) begin
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= {1'b1, tx_byte_c};
            o_uart_tx <= 1'b0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    o_uart_tx <= 1'b1;
                end else begin
                    o_uart_tx <= tx_shift[0];
                    tx_shift  <= {1'b1, tx_shift[8:1]};
                    tx_bit    <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    assign resp_total = is_write ? 3'd1 : 3'd5;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rx_valid && (rx_shift == CMD_WR || rx_shift == CMD_RD)) state_nxt = S_ADDR;
            S_ADDR: begin
                if (rx_ferr)                             state_nxt = S_IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   state_nxt = is_write ? S_DATA : S_BUS;
            end
            S_DATA: begin
                if (rx_ferr)                             state_nxt = S_IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   state_nxt = S_BUS;
            end
            S_BUS:  if (i_wb_err || i_wb_ack || timer == TMO_LAST) state_nxt = S_RESP;
            S_RESP: if (tx_done_c && resp_idx == resp_total) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_in_c   = 1'b0;
        bus_start_c = 1'b0;
        bus_end_c   = 1'b0;
        tx_load_c   = 1'b0;
        tx_byte_c   = status;
        if (state == S_ADDR || state == S_DATA) byte_in_c = rx_valid;
        if (state != S_BUS && state_nxt == S_BUS) bus_start_c = 1'b1;
        if (state == S_BUS && state_nxt == S_RESP) bus_end_c = 1'b1;
        if (state == S_RESP && (!tx_active || tx_done_c) && resp_idx != resp_total) tx_load_c = 1'b1;
        case (resp_idx)
            3'd0:    tx_byte_c = status;
            3'd1:    tx_byte_c = rdata[31:24];
            3'd2:    tx_byte_c = rdata[23:16];
            3'd3:    tx_byte_c = rdata[15:8];
            default: tx_byte_c = rdata[7:0];
        endcase
    end

    // Command collection, bus cycle and response bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt <= '0;
            is_write <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            status   <= '0;
            timer    <= '0;
            resp_idx <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_busy <= (state_nxt != S_IDLE);
            if (state == S_IDLE && state_nxt == S_ADDR) begin
                is_write <= (rx_shift == CMD_WR);
                byte_cnt <= '0;
            end
            if (byte_in_c) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (state == S_ADDR) addr  <= {addr[23:0], rx_shift};
                else                 wdata <= {wdata[23:0], rx_shift};
            end
            if (bus_start_c) begin
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
                o_wb_sel <= 4'hF;
                o_wb_we  <= is_write;
                o_wb_adr <= (state == S_ADDR) ? {addr[23:0], rx_shift} : addr;
                o_wb_dat <= (state == S_DATA) ? {wdata[23:0], rx_shift} : wdata;
                timer    <= '0;
            end else if (state == S_BUS) begin
                timer <= timer + 1'b1;
            end
            if (bus_end_c) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_sel <= 4'h0;
                o_wb_we  <= 1'b0;
                resp_idx <= '0;
                if (!i_wb_err && i_wb_ack) begin
                    status <= STS_OK;
                    rdata  <= i_wb_dat;
                end else begin
                    status <= STS_ERR;
                    rdata  <= '0;
                end
            end
            if (tx_load_c) resp_idx <= resp_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master: serial host driver, Wishbone responder
// and serial receiver feed hand-computed checks in one linear sequence.
module tb_wb_uart_master;

    localparam int CPB = 4;
    localparam int TMO = 16;
    localparam int SLV_NONE = 0;
    localparam int SLV_ACK  = 1;
    localparam int SLV_ERR  = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_uart_rx = 1'b1;
    logic        o_uart_tx;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_busy;

    wb_uart_master #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          fails = 0;
    int          base = 0;
    int          slv_mode = SLV_NONE;
    int          slv_delay = 1;
    logic [31:0] slv_rdata = '0;
    int          txn_count = 0;
    int          bus_len = 0;
    logic        cyc_prev = 1'b0;
    logic [31:0] lat_adr, lat_dat;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [7:0]  txq[$];
    int          t0;

    // Wishbone responder: ack/err on the slv_delay-th cycle that cyc is high
    always @(negedge i_clk) begin
        if (o_wb_cyc && o_wb_stb) begin
            if (!cyc_prev) begin
                txn_count = txn_count + 1;
                bus_len   = 0;
                lat_adr   = o_wb_adr;
                lat_dat   = o_wb_dat;
                lat_we    = o_wb_we;
                lat_sel   = o_wb_sel;
            end
            bus_len = bus_len + 1;
            if (slv_mode != SLV_NONE && bus_len == slv_delay) begin
                i_wb_ack = 1'b1;
                i_wb_err = (slv_mode == SLV_ERR);
                i_wb_dat = slv_rdata;
            end else begin
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
                i_wb_dat = '0;
            end
            cyc_prev = 1'b1;
        end else begin
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
            cyc_prev = 1'b0;
        end
    end

    // Serial receiver for the response line
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge o_uart_tx);
            repeat (CPB / 2) @(negedge i_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge i_clk);
                b[i] = o_uart_tx;
            end
            repeat (CPB) @(negedge i_clk);
            txq.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] txb(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_uart_rx = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (CPB) @(negedge i_clk);
        end
        i_uart_rx = stop;
        repeat (CPB) @(negedge i_clk);
        i_uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic expect_resp(input string tag, input int n, input logic [39:0] exp);
        int cnt = 0;
        while (txq.size() < base + n && cnt < 3000) begin
            @(negedge i_clk);
            cnt++;
        end
        check({tag, "_resp_arrived"}, 32'(txq.size() >= base + n), 32'd1);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(txb(base + i)), 32'(exp[8*(n-1-i) +: 8]));
        base = base + n;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_tx",  32'(o_uart_tx), 32'd1);
        check("rst_cyc", 32'(o_wb_cyc),  32'd0);
        check("rst_stb", 32'(o_wb_stb),  32'd0);
        check("rst_we",  32'(o_wb_we),   32'd0);
        check("rst_sel", 32'(o_wb_sel),  32'd0);
        check("rst_adr", o_wb_adr,       32'd0);
        check("rst_dat", o_wb_dat,       32'd0);
        check("rst_busy", 32'(o_busy),   32'd0);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);

        // Write, ack on the third cycle
        slv_mode = SLV_ACK; slv_delay = 3;
        t0 = txn_count;
        send_byte(8'h01, 1'b1);
        repeat (3) @(negedge i_clk);
        check("wr_busy_after_cmd", 32'(o_busy), 32'd1);
        send_word(32'h3000_1000);
        send_word(32'hDEAD_BEEF);
        expect_resp("wr", 1, 40'h00);
        check("wr_busy_in_stop", 32'(o_busy), 32'd1);
        repeat (4) @(negedge i_clk);
        check("wr_busy_fall", 32'(o_busy), 32'd0);
        check("wr_txn", 32'(txn_count - t0), 32'd1);
        check("wr_adr", lat_adr, 32'h3000_1000);
        check("wr_dat", lat_dat, 32'hDEAD_BEEF);
        check("wr_we",  32'(lat_we), 32'd1);
        check("wr_sel", 32'(lat_sel), 32'hF);
        check("wr_cyc_len", 32'(bus_len), 32'd3);

        // Read returning 0xA5
        slv_mode = SLV_ACK; slv_delay = 1; slv_rdata = 32'h0000_00A5;
        send_byte(8'h02, 1'b1);
        send_word(32'h30FF_FD00);
        expect_resp("rd", 5, 40'h00_0000_00A5);
        check("rd_adr", lat_adr, 32'h30FF_FD00);
        check("rd_we",  32'(lat_we), 32'd0);
        check("rd_cyc_len", 32'(bus_len), 32'd1);

        // Read with no responder: timeout after TMO cycles
        slv_mode = SLV_NONE;
        send_byte(8'h02, 1'b1);
        send_word(32'h4000_0004);
        expect_resp("tmo", 5, 40'hEE_0000_0000);
        check("tmo_cyc_len", 32'(bus_len), 32'(TMO));
        check("tmo_cyc_low", 32'(o_wb_cyc), 32'd0);

        // Write with err and ack together: err wins
        slv_mode = SLV_ERR; slv_delay = 2;
        send_byte(8'h01, 1'b1);
        send_word(32'h0000_0008);
        send_word(32'h1122_3344);
        expect_resp("err", 1, 40'hEE);
        check("err_cyc_len", 32'(bus_len), 32'd2);
        repeat (8) @(negedge i_clk);

        // Junk command byte
        t0 = txn_count;
        send_byte(8'h7F, 1'b1);
        repeat (4) @(negedge i_clk);
        check("junk_busy", 32'(o_busy), 32'd0);
        repeat (60) @(negedge i_clk);
        check("junk_txn", 32'(txn_count - t0), 32'd0);
        check("junk_no_tx", 32'(txq.size()), 32'(base));

        // One-cycle glitch on rx is not a start bit
        i_uart_rx = 1'b0;
        @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (30) @(negedge i_clk);
        check("glitch_busy", 32'(o_busy), 32'd0);

        // Framing error mid-packet returns to idle, next read is clean
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (10) @(negedge i_clk);
        check("ferr_busy", 32'(o_busy), 32'd0);
        check("ferr_txn", 32'(txn_count - t0), 32'd0);
        slv_mode = SLV_ACK; slv_delay = 2; slv_rdata = 32'h1234_5678;
        send_byte(8'h02, 1'b1);
        send_word(32'h0000_0010);
        expect_resp("ferr_rd", 5, 40'h00_1234_5678);
        check("ferr_rd_adr", lat_adr, 32'h0000_0010);
        check("ferr_rd_txn", 32'(txn_count - t0), 32'd1);

        // Reset while cyc is high
        slv_mode = SLV_NONE;
        send_byte(8'h02, 1'b1);
        send_word(32'h5000_0000);
        t0 = 0;
        while (!o_wb_cyc && t0 < 200) begin
            @(negedge i_clk);
            t0++;
        end
        check("rstbus_cyc_seen", 32'(o_wb_cyc), 32'd1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rstbus_cyc", 32'(o_wb_cyc), 32'd0);
        check("rstbus_stb", 32'(o_wb_stb), 32'd0);
        check("rstbus_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        repeat (20) @(negedge i_clk);
        check("rstbus_no_tx", 32'(o_uart_tx), 32'd1);

        // Reset in the middle of a response byte
        slv_mode = SLV_ACK; slv_delay = 1; slv_rdata = 32'h0;
        send_byte(8'h02, 1'b1);
        send_word(32'h6000_0000);
        t0 = 0;
        while (o_uart_tx && t0 < 200) begin
            @(negedge i_clk);
            t0++;
        end
        repeat (10) @(negedge i_clk);
        check("rsttx_line_low", 32'(o_uart_tx), 32'd0);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rsttx_tx", 32'(o_uart_tx), 32'd1);
        check("rsttx_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        repeat (60) @(negedge i_clk);
        base = txq.size();

        // Normal write after the resets
        t0 = txn_count;
        slv_mode = SLV_ACK; slv_delay = 2;
        send_byte(8'h01, 1'b1);
        send_word(32'h7000_0020);
        send_word(32'hCAFE_F00D);
        expect_resp("post_wr", 1, 40'h00);
        check("post_wr_adr", lat_adr, 32'h7000_0020);
        check("post_wr_dat", lat_dat, 32'hCAFE_F00D);
        check("post_wr_txn", 32'(txn_count - t0), 32'd1);
        repeat (10) @(negedge i_clk);
        check("post_wr_idle", 32'(o_busy), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
